serial_link_arbiter: RTL



---
 rtl/serial_link_arbiter_if.sv | 24 ++
 rtl/serial_link_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/serial_link_arbiter_if.sv
// Handshake/bus bundle for serial_link_arbiter: requester side and serial line side.
interface serial_link_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic                 clk_en;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   data;
  logic [NREQ-1:0]      grant;
  logic                 done;
  logic                 busy;
  logic                 ser_out;
  logic                 ser_valid;

  modport master (
    output clk_en, req, data,
    input  grant, done, busy, ser_out, ser_valid
  );

  modport slave (
    input  clk_en, req, data,
    output grant, done, busy, ser_out, ser_valid
  );
endinterface

// File: rtl/serial_link_arbiter.sv
// Round-robin arbiter that frames one requester's word onto a shared serial line:
// preamble, requester ID, payload MSB-first. Optional parity bit via SERIAL_PARITY_EN.
module serial_link_arbiter #(
  parameter int               NREQ  = 4,
  parameter int               DW    = 8,
  parameter int               PRE_W = 6,
  parameter logic [PRE_W-1:0] PRE   = 6'b110101
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_link_arbiter_if.slave bus
);

  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (PRE_W > DW) ? PRE_W : DW;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ID, S_DATA, S_PAR, S_GAP} state_t;

  state_t            state;
  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    id_sh;
  logic [CW-1:0]     cnt;
  logic [PRE_W-1:0]  pre_sh;
  logic [DW-1:0]     shreg;
  logic [NREQ-1:0]   grant_r;
  logic              done_r;
  logic              busy_r;
  logic              ser_out_r;
  logic              ser_valid_r;
`ifdef SERIAL_PARITY_EN
  logic              par_r;
`endif

  logic [2*NREQ-1:0] rot;
  logic [IDW-1:0]    win;
  logic              win_any;
  logic [DW-1:0]     win_word;

  // Rotating the doubled request vector by ptr makes the first set bit the round-robin winner.
  always_comb begin
    rot      = {bus.req, bus.req} >> ptr;
    win      = '0;
    win_any  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_any && rot[k]) begin
        win_any = 1'b1;
        win     = IDW'((int'(ptr) + k) % NREQ);
      end
    end
    win_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) win_word = bus.data[i*DW +: DW];
    end
  end

  // Each field entry emits the field's MSB immediately and keeps the rest in a left shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      id_sh       <= '0;
      cnt         <= '0;
      pre_sh      <= '0;
      shreg       <= '0;
      grant_r     <= '0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      ser_out_r   <= 1'b0;
      ser_valid_r <= 1'b0;
`ifdef SERIAL_PARITY_EN
      par_r       <= 1'b0;
`endif
    end else if (bus.clk_en) begin
      case (state)
        S_IDLE: begin
          if (win_any) begin
            grant_r   <= NREQ'(1) << win;
            shreg     <= win_word;
            id_sh     <= win;
            ptr       <= IDW'((int'(win) + 1) % NREQ);
            pre_sh    <= PRE << 1;
            ser_out_r <= PRE[PRE_W-1];
            cnt       <= '0;
            busy_r    <= 1'b1;
            state     <= S_PRE;
`ifdef SERIAL_PARITY_EN
            par_r     <= ^win_word;
`endif
          end
        end
        S_PRE: begin
          if (cnt == CW'(PRE_W-1)) begin
            cnt       <= '0;
            ser_out_r <= id_sh[IDW-1];
            id_sh     <= id_sh << 1;
            state     <= S_ID;
          end else begin
            cnt       <= cnt + CW'(1);
            ser_out_r <= pre_sh[PRE_W-1];
            pre_sh    <= pre_sh << 1;
          end
        end
        S_ID: begin
          if (cnt == CW'(IDW-1)) begin
            cnt         <= '0;
            ser_out_r   <= shreg[DW-1];
            shreg       <= shreg << 1;
            ser_valid_r <= 1'b1;
            state       <= S_DATA;
          end else begin
            cnt       <= cnt + CW'(1);
            ser_out_r <= id_sh[IDW-1];
            id_sh     <= id_sh << 1;
          end
        end
        S_DATA: begin
          if (cnt == CW'(DW-1)) begin
            cnt <= '0;
`ifdef SERIAL_PARITY_EN
            ser_out_r <= par_r;
            state     <= S_PAR;
`else
            ser_out_r   <= 1'b0;
            ser_valid_r <= 1'b0;
            grant_r     <= '0;
            done_r      <= 1'b1;
            state       <= S_GAP;
`endif
          end else begin
            cnt       <= cnt + CW'(1);
            ser_out_r <= shreg[DW-1];
            shreg     <= shreg << 1;
          end
        end
`ifdef SERIAL_PARITY_EN
        S_PAR: begin
          ser_out_r   <= 1'b0;
          ser_valid_r <= 1'b0;
          grant_r     <= '0;
          done_r      <= 1'b1;
          state       <= S_GAP;
        end
`endif
        S_GAP: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_r;
  assign bus.done      = done_r;
  assign bus.busy      = busy_r;
  assign bus.ser_out   = ser_out_r;
  assign bus.ser_valid = ser_valid_r;

endmodule
